// File: rtl/nfa_engine_pkg.sv
// Shared types and attribute-word layout for the programmable NFA engine.
// Holds the start-type and config-kind encodings plus the attribute decode helper.
package nfa_engine_pkg;

  typedef enum logic [1:0] {
    START_NONE = 2'd0,
    START_SOD  = 2'd1,
    START_ALL  = 2'd2
  } start_type_e;

  typedef enum logic [1:0] {
    CFG_CLASS = 2'd0,
    CFG_EDGE  = 2'd1,
    CFG_ATTR  = 2'd2,
    CFG_RSVD  = 2'd3
  } cfg_kind_e;

  localparam int ATTR_START_LSB  = 0;
  localparam int ATTR_START_MSB  = 1;
  localparam int ATTR_REPORT_BIT = 2;

  // Encoding 3 is unused and folds to START_NONE.
  function automatic start_type_e decode_start(input logic [1:0] v);
    case (v)
      2'd1:    return START_SOD;
      2'd2:    return START_ALL;
      default: return START_NONE;
    endcase
  endfunction

endpackage

// File: rtl/nfa_rpt_fifo.sv
// Report FIFO with registered storage; a push is visible at the head one cycle later.
// Zero-bubble: a full FIFO still accepts a push when the head pops in the same cycle.
module nfa_rpt_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ok,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             pop;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop     = valid && ready;
  assign push_ok = push && (!full || pop);
  assign data    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nfa_engine_prog.sv
// Runtime-programmable homogeneous NFA: one symbol per run cycle, active updates next edge.
// Reports are pushed into a ready/valid FIFO; when it is full and not popping, reports drop and are counted.
module nfa_engine_prog
  import nfa_engine_pkg::*;
#(
  parameter int NUM_STE   = 16,
  parameter int SYM_W     = 8,
  parameter int RPT_DEPTH = 8,
  parameter int CNT_W     = 32,
  localparam int STE_W    = (NUM_STE > 1) ? $clog2(NUM_STE) : 1,
  localparam int WORD_W   = (SYM_W > 5) ? SYM_W - 5 : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     restart,
  input  logic [SYM_W-1:0]         symbols,
  input  logic                     cfg_we,
  input  logic [1:0]               cfg_kind,
  input  logic [STE_W-1:0]         cfg_ste,
  input  logic [WORD_W-1:0]        cfg_word,
  input  logic [31:0]              cfg_wdata,
  output logic                     cfg_err,
  output logic [NUM_STE-1:0]       active,
  output logic                     rpt_valid,
  input  logic                     rpt_ready,
  output logic [CNT_W+NUM_STE-1:0] rpt_data,
  output logic                     rpt_overflow,
  output logic [CNT_W-1:0]         drop_cnt
);
  localparam int NWORDS = 2 ** (SYM_W - 5);

  logic [31:0]        cls       [NUM_STE][NWORDS];
  logic [NUM_STE-1:0] pred      [NUM_STE];
  start_type_e        start_t   [NUM_STE];
  logic [NUM_STE-1:0] report_en;
  logic               sod_armed;
  logic [CNT_W-1:0]   sym_idx;

  logic [NUM_STE-1:0] next_active;
  logic [NUM_STE-1:0] rep;
  logic [WORD_W-1:0]  sym_word;
  logic [4:0]         sym_bit;
  logic               en;
  logic               push;
  logic               push_ok;
  logic               fifo_full;
  logic               cfg_ok;

  assign sym_word = WORD_W'(symbols >> 5);
  assign sym_bit  = symbols[4:0];
  assign cfg_ok   = cfg_we && !run && (int'(cfg_ste) < NUM_STE);

  always_comb begin
    next_active = '0;
    en          = 1'b0;
    for (int i = 0; i < NUM_STE; i++) begin
      en = (|(active & pred[i])) || (start_t[i] == START_ALL) ||
           ((start_t[i] == START_SOD) && sod_armed);
      next_active[i] = en && cls[i][sym_word][sym_bit];
    end
  end

  assign rep  = next_active & report_en;
  assign push = run && !restart && (rep != '0);

  // Configuration store: class bitmaps, predecessor rows, start type and report enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STE; i++) begin
        for (int w = 0; w < NWORDS; w++) cls[i][w] <= '0;
        pred[i]    <= '0;
        start_t[i] <= START_NONE;
      end
      report_en <= '0;
    end else if (cfg_ok) begin
      case (cfg_kind_e'(cfg_kind))
        CFG_CLASS: cls[cfg_ste][cfg_word] <= cfg_wdata;
        CFG_EDGE:  pred[cfg_ste] <= cfg_wdata[NUM_STE-1:0];
        CFG_ATTR: begin
          start_t[cfg_ste]   <= decode_start(cfg_wdata[ATTR_START_MSB:ATTR_START_LSB]);
          report_en[cfg_ste] <= cfg_wdata[ATTR_REPORT_BIT];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active    <= '0;
      sym_idx   <= '0;
      sod_armed <= 1'b1;
    end else if (restart) begin
      active    <= '0;
      sym_idx   <= '0;
      sod_armed <= 1'b1;
    end else if (run) begin
      active    <= next_active;
      sym_idx   <= sym_idx + 1'b1;
      sod_armed <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_err      <= 1'b0;
      rpt_overflow <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      if (cfg_we && run) cfg_err <= 1'b1;
      if (push && !push_ok) begin
        rpt_overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  nfa_rpt_fifo #(
    .WIDTH (CNT_W + NUM_STE),
    .DEPTH (RPT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({sym_idx, rep}),
    .push_ok   (push_ok),
    .valid     (rpt_valid),
    .ready     (rpt_ready),
    .data      (rpt_data),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_nfa_engine_prog.sv
// Directed bench for nfa_engine_prog: scoreboard queue of expected reports, checked on pop.
module tb_nfa_engine_prog;

  logic        clk;
  logic        reset;
  logic        run;
  logic        restart;
  logic [7:0]  symbols;
  logic        cfg_we;
  logic [1:0]  cfg_kind;
  logic [3:0]  cfg_ste;
  logic [2:0]  cfg_word;
  logic [31:0] cfg_wdata;
  logic        cfg_err;
  logic [15:0] active;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [47:0] rpt_data;
  logic        rpt_overflow;
  logic [31:0] drop_cnt;

  int          errors;
  int          checks;
  logic [47:0] q[$];
  logic [31:0] exp_idx;
  int          drops;

  nfa_engine_prog #(
    .NUM_STE   (16),
    .SYM_W     (8),
    .RPT_DEPTH (8),
    .CNT_W     (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .restart      (restart),
    .symbols      (symbols),
    .cfg_we       (cfg_we),
    .cfg_kind     (cfg_kind),
    .cfg_ste      (cfg_ste),
    .cfg_word     (cfg_word),
    .cfg_wdata    (cfg_wdata),
    .cfg_err      (cfg_err),
    .active       (active),
    .rpt_valid    (rpt_valid),
    .rpt_ready    (rpt_ready),
    .rpt_data     (rpt_data),
    .rpt_overflow (rpt_overflow),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] ent(input logic [31:0] idx, input logic [15:0] rep);
    return {idx, rep};
  endfunction

  // All tasks are entered and left on a falling edge.
  task automatic cfg(input logic [1:0] k, input logic [3:0] s, input logic [2:0] w,
                     input logic [31:0] d);
    cfg_kind = k; cfg_ste = s; cfg_word = w; cfg_wdata = d; cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Scoreboard model: a report enters the queue only if the FIFO (depth 8) has room.
  task automatic feed(input logic [7:0] s, input logic [15:0] rep);
    run = 1'b1; symbols = s;
    if (rep != 16'h0) begin
      if (q.size() < 8) q.push_back(ent(exp_idx, rep));
      else drops++;
    end
    exp_idx++;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1; run = 1'b1; symbols = 8'h01;
    @(negedge clk);
    restart = 1'b0; run = 1'b0;
    exp_idx = '0;
  endtask

  task automatic pop_check(input string tag);
    logic [47:0] exp;
    int n;
    n = 0;
    while (!rpt_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp = (q.size() != 0) ? q.pop_front() : '1;
    chk(tag, {15'h0, rpt_valid, rpt_data}, {15'h0, 1'b1, exp});
    rpt_ready = 1'b1;
    @(negedge clk);
    rpt_ready = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0; exp_idx = '0; drops = 0;
    reset = 1'b1; run = 1'b0; restart = 1'b0; symbols = '0;
    cfg_we = 1'b0; cfg_kind = '0; cfg_ste = '0; cfg_word = '0; cfg_wdata = '0;
    rpt_ready = 1'b0;

    #3;
    chk("rst_active", active, 0);
    chk("rst_valid", rpt_valid, 0);
    chk("rst_data", rpt_data, 0);
    chk("rst_flags", {cfg_err, rpt_overflow}, 0);
    chk("rst_drop", drop_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    // Chain: STE0 (start-of-data, 'A') -> STE1 ('B', reports).
    cfg(2'd0, 4'd0, 3'd2, 32'h0000_0002);
    cfg(2'd0, 4'd1, 3'd2, 32'h0000_0004);
    cfg(2'd1, 4'd1, 3'd0, 32'h0000_0001);
    cfg(2'd2, 4'd0, 3'd0, 32'h0000_0001);
    cfg(2'd2, 4'd1, 3'd0, 32'h0000_0004);
    feed(8'h41, 16'h0000);
    chk("chain_act0", active, 16'h0001);
    chk("chain_noval", rpt_valid, 0);
    feed(8'h42, 16'h0002);
    chk("chain_act1", active, 16'h0002);
    pop_check("chain_rpt");

    // All-input start with self-loop on 0x00..0x0F.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete(); exp_idx = '0; drops = 0;
    cfg(2'd0, 4'd3, 3'd0, 32'h0000_FFFF);
    cfg(2'd1, 4'd3, 3'd0, 32'h0000_0008);
    cfg(2'd2, 4'd3, 3'd0, 32'h0000_0006);
    feed(8'h05, 16'h0008);
    chk("all_act0", active, 16'h0008);
    feed(8'h30, 16'h0000);
    chk("all_act1", active, 16'h0000);
    feed(8'h07, 16'h0008);
    chk("all_act2", active, 16'h0008);
    pop_check("all_rpt0");
    pop_check("all_rpt2");

    // Overflow: ten reports against a depth-8 FIFO with no consumer.
    do_restart();
    for (int i = 0; i < 10; i++) feed(8'h01, 16'h0008);
    chk("ovf_flag", rpt_overflow, 1);
    chk("ovf_drop", drop_cnt, drops);
    chk("ovf_stable0", rpt_data, q[0]);
    @(negedge clk);
    chk("ovf_stable1", rpt_data, q[0]);
    for (int i = 0; i < 8; i++) pop_check($sformatf("ovf_drain%0d", i));
    chk("ovf_empty", rpt_valid, 0);

    // Full FIFO with push and pop in the same cycle.
    do_restart();
    for (int i = 0; i < 8; i++) feed(8'h01, 16'h0008);
    chk("simul_head", {rpt_valid, rpt_data}, {1'b1, q[0]});
    void'(q.pop_front());
    q.push_back(ent(exp_idx, 16'h0008));
    exp_idx++;
    rpt_ready = 1'b1; run = 1'b1; symbols = 8'h01;
    @(negedge clk);
    rpt_ready = 1'b0; run = 1'b0;
    chk("simul_drop", drop_cnt, drops);
    for (int i = 0; i < 8; i++) pop_check($sformatf("simul_drain%0d", i));

    // Config write while running is discarded and flagged.
    do_restart();
    run = 1'b1; symbols = 8'h01;
    cfg_we = 1'b1; cfg_kind = 2'd2; cfg_ste = 4'd3; cfg_wdata = 32'h0;
    q.push_back(ent(exp_idx, 16'h0008));
    exp_idx++;
    @(negedge clk);
    cfg_we = 1'b0; run = 1'b0;
    chk("cfgerr_flag", cfg_err, 1);
    feed(8'h01, 16'h0008);
    chk("cfgerr_keep", active, 16'h0008);
    pop_check("cfgerr_rpt0");
    pop_check("cfgerr_rpt1");

    // Restart mid-stream re-arms start-of-data STE5.
    cfg(2'd0, 4'd5, 3'd0, 32'h0000_0002);
    cfg(2'd2, 4'd5, 3'd0, 32'h0000_0005);
    do_restart();
    feed(8'h01, 16'h0028);
    chk("rs_act0", active, 16'h0028);
    feed(8'h01, 16'h0008);
    chk("rs_act1", active, 16'h0008);
    do_restart();
    chk("rs_cleared", active, 16'h0000);
    feed(8'h01, 16'h0028);
    chk("rs_act2", active, 16'h0028);
    pop_check("rs_rpt0");
    pop_check("rs_rpt1");
    pop_check("rs_rpt2");

    // Asynchronous reset between edges while a report is pending.
    feed(8'h01, 16'h0008);
    chk("ar_pending", rpt_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_active", active, 0);
    chk("ar_valid", {rpt_valid, rpt_data}, 0);
    chk("ar_flags", {cfg_err, rpt_overflow}, 0);
    chk("ar_drop", drop_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    q.delete(); exp_idx = '0; drops = 0;
    feed(8'h01, 16'h0000);
    chk("ar_cfg_cleared", {active, rpt_valid}, 0);
    chk("sb_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
